// File: rtl/pid_multi_ctrl.sv
// Multi-channel PID controller. One frame covers all NCH channels and is
// computed per accepted sample strobe. Every channel steps through
// ERR -> MP -> MI -> MD -> SUM, and all channels share one signed multiplier.
// The integrator is clamped to +/-IMAX (anti-windup). The output is
// drive = process + P + I + D, saturated to OW bits.
module pid_multi_ctrl #(
  parameter int NCH   = 4,
  parameter int DW    = 32,
  parameter int OW    = 40,
  parameter int SHIFT = 3,
  parameter int IMAX  = 2**20
) (
  input  logic                     clk,
  input  logic                     nRst,
  input  logic                     sample_valid,
  output logic                     sample_ready,
  input  logic [NCH*DW-1:0]        target,
  input  logic [NCH*DW-1:0]        process,
  input  logic signed [DW-1:0]     Kp,
  input  logic signed [DW-1:0]     Ki,
  input  logic signed [DW-1:0]     Kd,
  input  logic                     int_clear,
  output logic [NCH*OW-1:0]        drive,
  output logic                     drive_valid
);

  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int PW = 2*DW + 1;   // full product width: DW gain x (DW+1) operand
  localparam int SW = 2*DW + 4;   // headroom for the four-term sum

  localparam logic signed [DW:0] IMAX_P = (DW+1)'(IMAX);
  localparam logic signed [DW:0] IMAX_N = -IMAX_P;

  typedef enum logic [2:0] {IDLE, ERR, MP, MI, MD, SUM, DONE} state_t;

  state_t state, state_next;

  logic [CW-1:0]          ch;
  logic [NCH*DW-1:0]      tgt_lat, prc_lat;
  logic signed [DW-1:0]   kp_lat, ki_lat, kd_lat;
  logic signed [DW-1:0]   integ  [NCH];
  logic signed [DW-1:0]   e_prev [NCH];
  logic signed [OW-1:0]   shadow [NCH];
  logic signed [OW-1:0]   drive_r [NCH];
  logic signed [DW-1:0]   e_r, inew_r;
  logic signed [DW:0]     d_r;
  logic signed [PW-1:0]   p_term, i_term, d_term;

  logic                   last_ch;
  logic signed [DW-1:0]   cur_t, cur_p, e_calc, inew_calc;
  logic signed [DW:0]     diff, isum, d_calc;
  logic signed [DW-1:0]   mul_a;
  logic signed [DW:0]     mul_b;
  logic signed [PW-1:0]   mul_y;
  logic signed [SW-1:0]   sum_w;
  logic signed [OW-1:0]   sum_sat;

  // Clip a (DW+1)-bit value to the signed DW-bit range.
  function automatic logic signed [DW-1:0] sat_dw(input logic signed [DW:0] v);
    if (v[DW] == v[DW-1]) return v[DW-1:0];
    else if (v[DW])       return {1'b1, {(DW-1){1'b0}}};
    else                  return {1'b0, {(DW-1){1'b1}}};
  endfunction

  // Clip the wide sum to the signed OW-bit range.
  function automatic logic signed [OW-1:0] sat_ow(input logic signed [SW-1:0] v);
    if (v[SW-1:OW-1] == {(SW-OW+1){v[SW-1]}}) return v[OW-1:0];
    else if (v[SW-1])                          return {1'b1, {(OW-1){1'b0}}};
    else                                       return {1'b0, {(OW-1){1'b1}}};
  endfunction

  assign sample_ready = (state == IDLE);
  assign drive_valid  = (state == DONE);
  assign last_ch      = (ch == CW'(NCH-1));

  // State register
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic: five steps per channel, then a single DONE cycle
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (sample_valid) state_next = ERR;
      ERR:     state_next = MP;
      MP:      state_next = MI;
      MI:      state_next = MD;
      MD:      state_next = SUM;
      SUM:     state_next = last_ch ? DONE : ERR;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Error, clamped integrator and difference for the current channel
  always_comb begin
    cur_t     = tgt_lat[ch*DW +: DW];
    cur_p     = prc_lat[ch*DW +: DW];
    diff      = (DW+1)'(cur_t) - (DW+1)'(cur_p);
    e_calc    = sat_dw(diff);
    isum      = (DW+1)'(integ[ch]) + (DW+1)'(e_calc);
    inew_calc = isum[DW-1:0];
    if (isum > IMAX_P)      inew_calc = IMAX_P[DW-1:0];
    else if (isum < IMAX_N) inew_calc = IMAX_N[DW-1:0];
    d_calc    = (DW+1)'(e_calc) - (DW+1)'(e_prev[ch]);
  end

  // Shared multiplier operand select (gain x operand of the current step)
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state)
      MP:      begin mul_a = kp_lat; mul_b = (DW+1)'(e_r);    end
      MI:      begin mul_a = ki_lat; mul_b = (DW+1)'(inew_r); end
      MD:      begin mul_a = kd_lat; mul_b = d_r;             end
      default: begin mul_a = '0;     mul_b = '0;              end
    endcase
  end

  assign mul_y   = PW'(mul_a) * PW'(mul_b);
  assign sum_w   = SW'(cur_p) + SW'(p_term) + SW'(i_term) + SW'(d_term);
  assign sum_sat = sat_ow(sum_w);

  // Datapath: input latch, per-step registers, channel state commit and frame publish
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      ch      <= '0;
      tgt_lat <= '0;
      prc_lat <= '0;
      kp_lat  <= '0;
      ki_lat  <= '0;
      kd_lat  <= '0;
      e_r     <= '0;
      inew_r  <= '0;
      d_r     <= '0;
      p_term  <= '0;
      i_term  <= '0;
      d_term  <= '0;
      for (int c = 0; c < NCH; c++) begin
        integ[c]   <= '0;
        e_prev[c]  <= '0;
        shadow[c]  <= '0;
        drive_r[c] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          // The clear lands first, so a coincident frame starts from zero.
          if (int_clear) begin
            for (int c = 0; c < NCH; c++) begin
              integ[c]  <= '0;
              e_prev[c] <= '0;
            end
          end
          if (sample_valid) begin
            tgt_lat <= target;
            prc_lat <= process;
            kp_lat  <= Kp;
            ki_lat  <= Ki;
            kd_lat  <= Kd;
            ch      <= '0;
          end
        end
        ERR: begin
          e_r    <= e_calc;
          inew_r <= inew_calc;
          d_r    <= d_calc;
        end
        MP: p_term <= mul_y >>> SHIFT;
        MI: i_term <= mul_y >>> SHIFT;
        MD: d_term <= mul_y >>> SHIFT;
        SUM: begin
          integ[ch]  <= inew_r;
          e_prev[ch] <= e_r;
          shadow[ch] <= sum_sat;
          if (last_ch) begin
            // Publish the whole frame at once. The last channel is taken
            // directly from this cycle's sum.
            for (int c = 0; c < NCH; c++)
              drive_r[c] <= (CW'(c) == ch) ? sum_sat : shadow[c];
            ch <= '0;
          end else begin
            ch <= ch + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_pack
      assign drive[gi*OW +: OW] = drive_r[gi];
    end
  endgenerate

endmodule

// File: tb/tb_pid_multi_ctrl.sv
// Scoreboard bench for pid_multi_ctrl. A wide-integer model computes the
// expected frame and its due cycle at each accept and queues them. A
// negedge monitor pops one entry per drive_valid pulse and compares it.
module tb_pid_multi_ctrl;
  localparam int NCH = 4, DW = 32, OW = 40, SHIFT = 3, IMAX = 1000;
  localparam int LAT = 5*NCH + 1;

  typedef logic signed [127:0] big_t;
  typedef struct {
    logic [NCH*OW-1:0] drv;
    int                cyc;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 nRst = 1'b0;
  logic                 sample_valid = 1'b0;
  logic                 sample_ready;
  logic [NCH*DW-1:0]    target = '0;
  logic [NCH*DW-1:0]    process = '0;
  logic signed [DW-1:0] Kp = '0, Ki = '0, Kd = '0;
  logic                 int_clear = 1'b0;
  logic [NCH*OW-1:0]    drive;
  logic                 drive_valid;

  exp_t q[$];
  int   checks = 0, errors = 0, cyc = 0, pulses = 0;
  big_t m_int[NCH], m_prev[NCH];
  int   tv[NCH], pv[NCH];

  pid_multi_ctrl #(.NCH(NCH), .DW(DW), .OW(OW), .SHIFT(SHIFT), .IMAX(IMAX)) dut (
    .clk(clk), .nRst(nRst), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .target(target), .process(process), .Kp(Kp), .Ki(Ki), .Kd(Kd),
    .int_clear(int_clear), .drive(drive), .drive_valid(drive_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic big_t satw(input big_t v, input int w);
    big_t hi, lo;
    hi = (big_t'(1) <<< (w-1)) - 1;
    lo = -hi - 1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  task automatic model_clear();
    for (int c = 0; c < NCH; c++) begin
      m_int[c]  = 0;
      m_prev[c] = 0;
    end
  endtask

  // Reference PID step for a whole frame, in plain wide arithmetic.
  task automatic model_frame(input int kp, input int ki, input int kd, input bit clr, input int due);
    exp_t x;
    big_t e, inew, d, pt, it, dt, o;
    if (clr) model_clear();
    x.drv = '0;
    for (int c = 0; c < NCH; c++) begin
      e    = satw(big_t'(tv[c]) - big_t'(pv[c]), DW);
      inew = m_int[c] + e;
      if (inew > big_t'(IMAX))  inew = big_t'(IMAX);
      if (inew < -big_t'(IMAX)) inew = -big_t'(IMAX);
      d    = e - m_prev[c];
      pt   = (big_t'(kp) * e)    >>> SHIFT;
      it   = (big_t'(ki) * inew) >>> SHIFT;
      dt   = (big_t'(kd) * d)    >>> SHIFT;
      o    = satw(big_t'(pv[c]) + pt + it + dt, OW);
      m_int[c]  = inew;
      m_prev[c] = e;
      x.drv[c*OW +: OW] = o[OW-1:0];
    end
    x.cyc = due;
    q.push_back(x);
  endtask

  // Offer one frame once the DUT is ready; the caller sits at a negedge.
  task automatic send(input int kp, input int ki, input int kd, input bit clr);
    int n;
    n = 0;
    while (!sample_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!sample_ready) begin
      checks++; errors++;
      $display("FAIL ready_timeout: sample_ready=%0b required 1", sample_ready);
      return;
    end
    Kp = kp; Ki = ki; Kd = kd;
    for (int c = 0; c < NCH; c++) begin
      target[c*DW +: DW]  = tv[c];
      process[c*DW +: DW] = pv[c];
    end
    int_clear    = clr;
    sample_valid = 1'b1;
    model_frame(kp, ki, kd, clr, cyc + LAT);
    @(negedge clk);
    sample_valid = 1'b0;
    int_clear    = 1'b0;
  endtask

  task automatic clear_only();
    int n;
    n = 0;
    while (!sample_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    int_clear = 1'b1;
    model_clear();
    @(negedge clk);
    int_clear = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q.size() != 0 || !sample_ready) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drive_valid_timeout: pending=%0d required 0", q.size());
    end
  endtask

  task automatic set_all(input int t, input int p);
    for (int c = 0; c < NCH; c++) begin
      tv[c] = t;
      pv[c] = p;
    end
  endtask

  // Monitor: each drive_valid pulse must match the oldest expected frame.
  always @(negedge clk) begin : mon
    exp_t x;
    if (nRst && drive_valid) begin
      pulses++;
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_drive_valid: pulse at cycle %0d with no frame pending", cyc);
      end else begin
        x = q.pop_front();
        checks++;
        if (cyc != x.cyc) begin
          errors++;
          $display("FAIL latency: drive_valid at cycle %0d required %0d", cyc, x.cyc);
        end
        for (int c = 0; c < NCH; c++) begin
          checks++;
          if (drive[c*OW +: OW] !== x.drv[c*OW +: OW]) begin
            errors++;
            $display("FAIL drive%0d: got %0d required %0d", c,
                     $signed(drive[c*OW +: OW]), $signed(x.drv[c*OW +: OW]));
          end
        end
        $display("frame cyc=%0d drive0=%0d drive1=%0d drive2=%0d drive3=%0d", cyc,
                 $signed(drive[0*OW +: OW]), $signed(drive[1*OW +: OW]),
                 $signed(drive[2*OW +: OW]), $signed(drive[3*OW +: OW]));
      end
    end
  end

  task automatic check_reset_state(input string tag);
    checks++;
    if (drive !== '0) begin
      errors++;
      $display("FAIL %s_drive: got %0h required 0", tag, drive);
    end
    checks++;
    if (drive_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_drive_valid: got %0b required 0", tag, drive_valid);
    end
    checks++;
    if (sample_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_sample_ready: got %0b required 1", tag, sample_ready);
    end
  endtask

  initial begin
    int p0;
    model_clear();
    // Reset is held with nonzero inputs applied.
    set_all(123, 45);
    for (int c = 0; c < NCH; c++) begin
      target[c*DW +: DW]  = tv[c];
      process[c*DW +: DW] = pv[c];
    end
    Kp = 5; Ki = 6; Kd = 7; sample_valid = 1'b1; int_clear = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    sample_valid = 1'b0; int_clear = 1'b0;
    nRst = 1'b1;
    @(negedge clk);

    // P only: drive0 = 40 + 60.
    set_all(100, 40);
    send(8, 0, 0, 1'b0);
    wait_idle();

    // Integrator accumulation, then a coincident clear and a standalone clear.
    set_all(10, 0);
    send(0, 8, 0, 1'b1);
    send(0, 8, 0, 1'b0);
    send(0, 8, 0, 1'b0);
    send(0, 8, 0, 1'b1);
    wait_idle();
    clear_only();
    send(0, 8, 0, 1'b0);
    wait_idle();

    // Anti-windup clamp.
    set_all(600, 0);
    send(0, 8, 0, 1'b1);
    send(0, 8, 0, 1'b0);
    send(0, 8, 0, 1'b0);
    wait_idle();

    // D term, then positive and negative output saturation.
    set_all(0, 0);
    send(0, 0, 8, 1'b1);
    set_all(50, 0);
    send(0, 0, 8, 1'b0);
    set_all(32'sh7fffffff, 0);
    send(32'sh7fffffff, 0, 0, 1'b0);
    set_all(32'sh80000000, 32'sh7fffffff);
    send(32'sh7fffffff, 0, 0, 1'b0);
    wait_idle();

    // sample_valid pulses while busy are ignored.
    p0 = pulses;
    set_all(77, 11);
    send(3, 2, 1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      target = {$urandom, $urandom, $urandom, $urandom};
      sample_valid = 1'b1;
      @(negedge clk);
      sample_valid = 1'b0;
      @(negedge clk);
    end
    wait_idle();
    repeat (5) @(negedge clk);
    checks++;
    if (pulses - p0 != 1) begin
      errors++;
      $display("FAIL busy_ignore: pulses=%0d required 1", pulses - p0);
    end

    // Reset mid-frame discards the frame and clears all state.
    p0 = pulses;
    set_all(500, -20);
    send(9, 9, 9, 1'b0);
    repeat (8) @(negedge clk);
    nRst = 1'b0;
    q.delete();
    model_clear();
    @(negedge clk);
    check_reset_state("midreset");
    nRst = 1'b1;
    repeat (30) @(negedge clk);
    checks++;
    if (pulses != p0) begin
      errors++;
      $display("FAIL midreset_pulse: pulses=%0d required 0", pulses - p0);
    end

    // Randomized frames against the reference model.
    for (int it = 0; it < 40; it++) begin
      int kp, ki, kd;
      bit clr;
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(0, 3) == 0) begin
          tv[c] = int'($urandom);
          pv[c] = int'($urandom);
        end else begin
          tv[c] = int'($urandom_range(0, 4000)) - 2000;
          pv[c] = int'($urandom_range(0, 4000)) - 2000;
        end
      end
      if ($urandom_range(0, 4) == 0) begin
        kp = int'($urandom); ki = int'($urandom); kd = int'($urandom);
      end else begin
        kp = int'($urandom_range(0, 200)) - 100;
        ki = int'($urandom_range(0, 200)) - 100;
        kd = int'($urandom_range(0, 200)) - 100;
      end
      clr = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 9) == 0) clear_only();
      send(kp, ki, kd, clr);
    end
    wait_idle();
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
